// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: oldest-first ALU reservation station that snoops NUM_CDB result buses.
// Optional RS_BYPASS_EN: an entry woken by the CDB may be selected in that same cycle.
module rs_multi_cdb #(
  parameter int NUM_ENTRIES = 8,
  parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES),
  parameter int NUM_CDB     = 2,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 6,
  parameter int FUNC_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           load,
  input  logic [FUNC_W-1:0]              func,
  input  logic [ROB_TAG_LEN-1:0]         t1,
  input  logic [ROB_TAG_LEN-1:0]         t2,
  input  logic                           ready1,
  input  logic                           ready2,
  input  logic [XLEN-1:0]                v1,
  input  logic [XLEN-1:0]                v2,
  input  logic [XLEN-1:0]                pc,
  input  logic [XLEN-1:0]                imm,
  input  logic [ROB_TAG_LEN-1:0]         dst,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]        cdb_value,
  input  logic                           issue,
  output logic                           insn_ready,
  output logic                           is_full,
  output logic [ENTRY_WIDTH:0]           free_count,
  output logic                           start,
  output logic [FUNC_W-1:0]              func_out,
  output logic [XLEN-1:0]                v1_out,
  output logic [XLEN-1:0]                v2_out,
  output logic [XLEN-1:0]                pc_out,
  output logic [XLEN-1:0]                imm_out,
  output logic [ROB_TAG_LEN-1:0]         dst_tag
);
  logic [NUM_ENTRIES-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d, elig, sel;
  logic [NUM_ENTRIES-1:0] ahead_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ahead_d [NUM_ENTRIES];
  logic [XLEN-1:0] v1_q [NUM_ENTRIES];
  logic [XLEN-1:0] v1_d [NUM_ENTRIES];
  logic [XLEN-1:0] v2_q [NUM_ENTRIES];
  logic [XLEN-1:0] v2_d [NUM_ENTRIES];
  logic [XLEN-1:0] pc_q [NUM_ENTRIES];
  logic [XLEN-1:0] imm_q [NUM_ENTRIES];
  logic [ROB_TAG_LEN-1:0] t1_q [NUM_ENTRIES];
  logic [ROB_TAG_LEN-1:0] t2_q [NUM_ENTRIES];
  logic [ROB_TAG_LEN-1:0] dst_q [NUM_ENTRIES];
  logic [FUNC_W-1:0] func_q [NUM_ENTRIES];
  logic [XLEN:0] s1 [NUM_ENTRIES];
  logic [XLEN:0] s2 [NUM_ENTRIES];
  logic [XLEN:0] si1, si2;
  logic [ENTRY_WIDTH-1:0] sel_idx, free_idx;
  logic do_load, fire;
  logic [XLEN-1:0] iv1, iv2;
  logic start_q;
  logic [FUNC_W-1:0] func_out_q;
  logic [XLEN-1:0] v1_out_q, v2_out_q, pc_out_q, imm_out_q;
  logic [ROB_TAG_LEN-1:0] dst_tag_q;

  // Returns {hit, value}; the lowest-numbered matching channel wins.
  function automatic logic [XLEN:0] snoop(input logic [ROB_TAG_LEN-1:0] t,
                                          input logic [NUM_CDB-1:0] cv,
                                          input logic [NUM_CDB*ROB_TAG_LEN-1:0] ct,
                                          input logic [NUM_CDB*XLEN-1:0] cd);
    logic [XLEN:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cv[k] && ct[k*ROB_TAG_LEN +: ROB_TAG_LEN] == t) r = {1'b1, cd[k*XLEN +: XLEN]};
    return r;
  endfunction

  // ahead_q[i][k] set means entry k was loaded before entry i; select the entry nobody eligible is ahead of.
  always_comb begin
    si1 = snoop(t1, cdb_valid, cdb_tag, cdb_value);
    si2 = snoop(t2, cdb_valid, cdb_tag, cdb_value);
    sel_idx = '0;
    free_idx = '0;
    free_count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      s1[i] = snoop(t1_q[i], cdb_valid, cdb_tag, cdb_value);
      s2[i] = snoop(t2_q[i], cdb_valid, cdb_tag, cdb_value);
`ifdef RS_BYPASS_EN
      elig[i] = valid_q[i] && (rdy1_q[i] || s1[i][XLEN]) && (rdy2_q[i] || s2[i][XLEN]);
`else
      elig[i] = valid_q[i] && rdy1_q[i] && rdy2_q[i];
`endif
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel[i] = elig[i] && !(|(elig & ahead_q[i]));
      if (sel[i]) sel_idx = ENTRY_WIDTH'(i);
      if (!valid_q[NUM_ENTRIES-1-i]) free_idx = ENTRY_WIDTH'(NUM_ENTRIES-1-i);
      free_count = free_count + (ENTRY_WIDTH+1)'(!valid_q[i]);
    end
  end

  assign insn_ready = |elig;
  assign is_full    = &valid_q;
  assign do_load    = load && !is_full && !flush;
  assign fire       = issue && insn_ready && !flush;
  assign iv1        = rdy1_q[sel_idx] ? v1_q[sel_idx] : s1[sel_idx][XLEN-1:0];
  assign iv2        = rdy2_q[sel_idx] ? v2_q[sel_idx] : s2[sel_idx][XLEN-1:0];

  always_comb begin
    valid_d = valid_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    ahead_d = ahead_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!rdy1_q[i] && s1[i][XLEN]) begin
        rdy1_d[i] = 1'b1;
        v1_d[i] = s1[i][XLEN-1:0];
      end
      if (!rdy2_q[i] && s2[i][XLEN]) begin
        rdy2_d[i] = 1'b1;
        v2_d[i] = s2[i][XLEN-1:0];
      end
      if (do_load) ahead_d[i][free_idx] = 1'b0;
    end
    if (fire) valid_d[sel_idx] = 1'b0;
    if (do_load) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx] = ready1 || si1[XLEN];
      rdy2_d[free_idx] = ready2 || si2[XLEN];
      v1_d[free_idx] = ready1 ? v1 : si1[XLEN-1:0];
      v2_d[free_idx] = ready2 ? v2 : si2[XLEN-1:0];
      ahead_d[free_idx] = valid_q;
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      start_q <= 1'b0;
      func_out_q <= '0;
      v1_out_q <= '0;
      v2_out_q <= '0;
      pc_out_q <= '0;
      imm_out_q <= '0;
      dst_tag_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ahead_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      ahead_q <= ahead_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      start_q <= fire;
      if (fire) begin
        func_out_q <= func_q[sel_idx];
        v1_out_q <= iv1;
        v2_out_q <= iv2;
        pc_out_q <= pc_q[sel_idx];
        imm_out_q <= imm_q[sel_idx];
        dst_tag_q <= dst_q[sel_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_load) begin
      t1_q[free_idx] <= t1;
      t2_q[free_idx] <= t2;
      dst_q[free_idx] <= dst;
      func_q[free_idx] <= func;
      pc_q[free_idx] <= pc;
      imm_q[free_idx] <= imm;
    end
  end

  assign start    = start_q;
  assign func_out = func_out_q;
  assign v1_out   = v1_out_q;
  assign v2_out   = v2_out_q;
  assign pc_out   = pc_out_q;
  assign imm_out  = imm_out_q;
  assign dst_tag  = dst_tag_q;
endmodule
